// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side streamer.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH  = 2;
  localparam int DATA_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer: push at tail, pop at head, head always registered.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        occ_o,
  output logic              head_vld_o,
  output logic [DATA_W-1:0] head_data_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              pop_ok;

  // A pop is only honoured when the head holds a word.
  assign pop_ok = pop_i && (occ_q != 2'd0);

  // Next-state: shift tail into head on pop, place pushed word in first free slot.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_i, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = push_data_i;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = push_data_i;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps order; occupancy unchanged.
        if (occ_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o       = occ_q;
  assign head_vld_o  = (occ_q != 2'd0);
  assign head_data_o = head_q;

  logic unused_depth;
  assign unused_depth = (BUF_DEPTH == 2);

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains a registered-read FIFO into a valid/ready stream with burst last flags.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [7:0]        beat_cnt,
  output logic              busy
);

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  state_e     state_q, state_d;
  logic       inflight_q;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] occ;
  logic       pop;
  logic [2:0] pending;

  assign pop = m_valid && m_ready;

  // Words that will occupy the buffer after this edge if no new read is issued.
  assign pending = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

  assign fifo_rd_en = (state_q == RUN) && !fifo_empty && (pending < 3'd2);

  fifo_skid_buf #(.DATA_W(DATA_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_vld_o  (m_valid),
    .head_data_o (m_data)
  );

  assign m_last = m_valid && (beat_cnt_q == LAST_CNT);
  assign busy   = (occ != 2'd0) || inflight_q;

  // Next-state: IDLE waits for en, RUN issues reads, DRAIN empties what is in flight.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                                 state_d = RUN;
        else if ((occ == 2'd0) && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) beat_cnt_d = m_last ? 8'd0 : beat_cnt_q + 8'd1;
  end

  // State, read-in-flight marker and burst beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench: FIFO model + expected-word queue, monitor checks every beat.
module tb_fifo_rd_streamer;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [7:0]    beat_cnt;
  logic          busy;

  fifo_rd_streamer #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .beat_cnt     (beat_cnt),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic [DW-1:0] push_q[$];
  logic [DW-1:0] mem[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Synchronous FIFO model: registered read data, writes land at the next edge.
  always @(posedge clk) begin
    if (rst) begin
      mem.delete();
      fifo_rd_data <= '0;
      fifo_empty   <= 1'b1;
    end else begin
      if (fifo_rd_en && mem.size() > 0) fifo_rd_data <= mem.pop_front();
      while (push_q.size() > 0) mem.push_back(push_q.pop_front());
      fifo_empty <= (mem.size() == 0);
    end
  end

  // Monitor: beat order/last/count, stall stability, no read while empty.
  initial begin
    int k;
    logic          prev_v, prev_r, prev_l;
    logic [DW-1:0] prev_d, e;
    k = 0; prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        k = 0;
        prev_v = 0;
      end else begin
        if (fifo_rd_en) chk("rd_en_while_empty", 32'(fifo_empty), 32'd0);
        if (prev_v && !prev_r) begin
          chk("stall_valid", 32'(m_valid), 32'd1);
          chk("stall_data", 32'(m_data), 32'(prev_d));
          chk("stall_last", 32'(m_last), 32'(prev_l));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(m_data), 32'(e));
            chk("beat_last", 32'(m_last), 32'((k % BL) == BL - 1));
            chk("beat_cnt", 32'(beat_cnt), 32'(k % BL));
            k++;
          end
        end
        prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    push_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic count_rd(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (fifo_rd_en) c++;
    end
  endtask

  task automatic wait_rd(input string nm, input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!fifo_rd_en && c < budget);
    chk(nm, 32'(fifo_rd_en), 32'd1);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(exp_q.size() == 0 && push_q.size() == 0 && !busy) && c < budget);
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [DW-1:0] first;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);

    // Four-word burst, full throughput, two-cycle latency
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) push_word(8'(i * 8'h11));
    en = 1'b1; m_ready = 1'b1;
    wait_rd("t1_first_rd", 20);
    chk("t1_valid_n", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t1_rd_n1", 32'(fifo_rd_en), 32'd1);
    chk("t1_valid_n1", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t1_rd_n2", 32'(fifo_rd_en), 32'd1);
    chk("t1_valid_n2", 32'(m_valid), 32'd1);
    chk("t1_data_n2", 32'(m_data), 32'h11);
    @(negedge clk);
    chk("t1_rd_n3", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    chk("t1_rd_n4", 32'(fifo_rd_en), 32'd0);
    chk("t1_valid_n4", 32'(m_valid), 32'd1);
    @(negedge clk);
    chk("t1_data_n5", 32'(m_data), 32'h44);
    chk("t1_last_n5", 32'(m_last), 32'd1);
    wait_drain("t1_drain", 50);

    // Stalled sink: exactly two reads, head held
    @(posedge clk); #1;
    m_ready = 1'b0;
    first = 8'($urandom);
    push_word(first);
    for (int i = 1; i < 8; i++) push_word(8'($urandom));
    count_rd(12, c);
    chk("t2_reads_stalled", 32'(c), 32'd2);
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_head", 32'(m_data), 32'(first));
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain("t2_drain", 60);

    // Toggling ready over twelve words
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) push_word(8'($urandom));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    wait_drain("t3_drain", 60);

    // en dropped in the read cycle: one word delivered, rest stays in FIFO
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_word(8'($urandom));
    wait_rd("t4_first_rd", 20);
    en = 1'b0;
    count_rd(10, c);
    chk("t4_no_more_reads", 32'(c), 32'd0);
    chk("t4_busy_low", 32'(busy), 32'd0);
    chk("t4_left_in_fifo", 32'(exp_q.size()), 32'd2);
    @(posedge clk); #1;
    en = 1'b1;
    wait_drain("t4_drain", 60);

    // Reset with a full buffer mid-burst
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    repeat (8) @(negedge clk);
    chk("t5_valid_before", 32'(m_valid), 32'd1);
    chk("t5_cnt_before", 32'(beat_cnt), 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("t5_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;

    // Single-word FIFO
    @(posedge clk); #1;
    push_word(8'hA5);
    count_rd(10, c);
    chk("t6_single_read", 32'(c), 32'd1);
    wait_drain("t6_drain", 30);

    // Randomized traffic with ready and en noise
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) push_word(8'($urandom));
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) en = ~en;
    end
    @(posedge clk); #1;
    en = 1'b1; m_ready = 1'b1;
    wait_drain("rand_drain", 400);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
